// File: rtl/clock_div_pkg.sv
// clock_div_pkg: shared types and defaults for the divided-clock controller
package clock_div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  localparam int DEF_DIV_W = 8;
  localparam int DEF_DIV = 17;
endpackage

// File: rtl/clock_div_ctrl_if.sv
// clock_div_ctrl_if: run control, config handshake and divided-clock outputs
interface clock_div_ctrl_if #(parameter int DIV_W = 8);
  logic enable;
  logic cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic cfg_ready;
  logic cfg_err;
  logic div_clock;
  logic tick;
  logic running;
  modport master (output enable, cfg_valid, cfg_div, input cfg_ready, cfg_err, div_clock, tick, running);
  modport slave (input enable, cfg_valid, cfg_div, output cfg_ready, cfg_err, div_clock, tick, running);
endinterface

// File: rtl/div_cfg_reg.sv
// div_cfg_reg: one-entry pending divide register with zero rejection
module div_cfg_reg #(parameter int DIV_W = 8) (
  input  logic clock,
  input  logic reset,
  input  logic cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic idle,
  input  logic bound,
  output logic cfg_ready,
  output logic cfg_err,
  output logic ld,
  output logic [DIV_W-1:0] ld_div
);
  logic pend_v, xfer, ok, apply;
  logic [DIV_W-1:0] pend;
  assign cfg_ready = !pend_v;
  assign xfer = cfg_valid & !pend_v;
  assign ok = xfer && cfg_div != '0;
  assign apply = pend_v & bound;
  assign ld = (ok & idle) | apply;
  assign ld_div = apply ? pend : cfg_div;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      pend_v <= 1'b0;
      pend <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= xfer && cfg_div == '0;
      pend_v <= (ok & !idle) | (pend_v & !bound);
      if (ok & !idle) pend <= cfg_div;
    end
endmodule

// File: rtl/clock_div_ctrl.sv
// clock_div_ctrl: glitch-free programmable clock divider with boundary-aligned ratio changes
module clock_div_ctrl
  import clock_div_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(DEF_DIV)
) (
  input logic clock,
  input logic reset,
  clock_div_ctrl_if.slave bus
);
  state_t state, nxt;
  logic [DIV_W-1:0] count, div_reg, ld_div;
  logic idle, tog, fall, bound, ld, dc_n;
  assign idle = state == IDLE;
  assign tog = !idle && count == div_reg - DIV_W'(1);
  assign fall = tog & bus.div_clock;
  // pending ratio lands on a full-period boundary or whenever we are (or go) idle
  assign bound = idle | fall | (nxt == IDLE);
  div_cfg_reg #(.DIV_W(DIV_W)) u_cfg (
    .clock(clock), .reset(reset), .cfg_valid(bus.cfg_valid), .cfg_div(bus.cfg_div),
    .idle(idle), .bound(bound), .cfg_ready(bus.cfg_ready), .cfg_err(bus.cfg_err),
    .ld(ld), .ld_div(ld_div)
  );
  always_comb begin
    nxt = state;
    nxt = bus.enable ? RUN : (idle || !bus.div_clock || fall) ? IDLE : STOPPING;
    dc_n = (nxt == IDLE) ? 1'b0 : tog ? !bus.div_clock : bus.div_clock;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      count <= '0;
      div_reg <= DEFAULT_DIV;
      bus.div_clock <= 1'b0;
      bus.tick <= 1'b0;
      bus.running <= 1'b0;
    end else begin
      state <= nxt;
      count <= (idle || nxt == IDLE || tog) ? '0 : count + DIV_W'(1);
      div_reg <= ld ? ld_div : div_reg;
      bus.div_clock <= dc_n;
      bus.tick <= dc_n & !bus.div_clock;
      bus.running <= nxt != IDLE;
    end
endmodule

// File: doc/clock_div_ctrl.md
Name: clock_div_ctrl

Overview:
- Run-time controller for the divided-clock datapath. It owns a programmable half-period counter and sequences start, stop and divide-ratio changes so that `div_clock` never glitches or truncates a high phase.
- Accepts new divide values over a valid/ready handshake and applies them only on full-period boundaries.
- Also emits a one-cycle `tick` enable for downstream logic clocked on `clock`.

Parameters:
- DIV_W, 8, width of the divide value and of the internal counter.
- DEFAULT_DIV, 17, divide value loaded at reset. Must be nonzero and < 2^DIV_W.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  level request to run the divided clock.
- cfg_valid  input  1  new divide value offered.
- cfg_div  input  DIV_W  offered half-period length, in clock cycles.
- cfg_ready  output  1  controller can accept a value this cycle.
- cfg_err  output  1  one-cycle pulse: offered value of 0 rejected.
- div_clock  output  1  divided clock; full period = 2*div_reg cycles.
- tick  output  1  one-cycle pulse in the cycle `div_clock` rises.
- running  output  1  high in RUN and STOPPING.

Behaviour:
- Reset values:
  - state=IDLE, count=0, div_reg=DEFAULT_DIV.
  - No pending value.
  - div_clock=0, tick=0, cfg_err=0, running=0.
  - cfg_ready=1.
- All outputs are registered.
- Half-period rule:
  - While counting, count increments each cycle.
  - When count==div_reg-1: count<=0 and div_clock toggles.
  - The counter is DIV_W bits; div_reg>=1 always holds.
- tick is 1 in the same cycle that div_clock registers 0->1, else 0.
- States: IDLE, RUN, STOPPING.
- IDLE:
  - count held at 0, div_clock=0.
  - enable=1 -> RUN next cycle. Counting starts in that cycle, so the first rise occurs div_reg cycles after entering RUN.
- RUN:
  - Counts per the half-period rule.
  - enable=0 with div_clock=0 -> IDLE next cycle, count<=0. Truncating a low phase is permitted.
  - enable=0 with div_clock=1 -> STOPPING.
- STOPPING:
  - Keeps counting.
  - At the toggle that drives div_clock 1->0 -> IDLE, count<=0.
  - enable=1 while in STOPPING -> RUN with no phase disturbance.
- Config handshake:
  - Transfer occurs on cfg_valid & cfg_ready.
  - cfg_ready = !pending_valid.
  - cfg_div==0: not stored; cfg_err pulses 1 in the next cycle; cfg_ready unaffected.
- Config in IDLE: div_reg<=cfg_div in the next cycle; no pending state.
- Config in RUN/STOPPING:
  - Value latched into pending and pending_valid<=1, so cfg_ready drops next cycle.
  - Applied at the next 1->0 toggle of div_clock (full-period boundary): div_reg<=pending, pending_valid<=0, count<=0.
  - If the state enters IDLE first, the value is applied on that same edge.
- Simultaneous events:
  - A transfer coinciding with the apply edge: the pending value is applied first; the new value becomes pending. cfg_ready is 0 in that cycle, so this arises only in IDLE, where the direct load wins.
  - enable falling and a config transfer in the same cycle are both honoured.
- Reset asserted mid-operation: immediate return to the reset values; any pending value is discarded.
- cfg_div is sampled only on transfer; later changes are ignored.

Decomposition:
- Shared package clock_div_pkg holds:
  - state enum typedef (IDLE, RUN, STOPPING);
  - DIV_W default;
  - DEFAULT_DIV.
- One natural sub-module, div_cfg_reg: one-entry pending register with valid/ready, the zero-reject check and the cfg_err pulse.
- The FSM, counter and div_clock stay in clock_div_ctrl.

Test Plan:
- Reset with DEFAULT_DIV=17, enable=1 -> div_clock high for 17 cycles, low for 17 cycles, repeating; tick every 34 cycles; running=1.
- In IDLE, cfg_div=3 transferred, then enable=1 -> period 6 cycles; tick at cycles 3, 9, 15 after entering RUN.
- While running at div 4 with div_clock high, cfg_div=2 transferred:
  - cfg_ready=0 until the next falling edge of div_clock;
  - subsequent phases 2 high / 2 low;
  - no phase shorter than 2 or longer than 4 cycles.
- cfg_valid=1 with cfg_div=0 -> cfg_err=1 for exactly one cycle; div_reg unchanged; period unchanged.
- enable dropped at div 5, two cycles into a high phase:
  - div_clock stays high 3 more cycles, then 0;
  - running=0 the cycle after;
  - re-enable during STOPPING keeps an unbroken 5/5 waveform.
- Reset asserted mid-high-phase with a pending value -> div_clock=0 and cfg_ready=1 immediately; after release div_reg=17.
